soc_lamp_ctrl: RTL and testbench
================================

SOC_LAMP_CTRL -- requirements
Module: soc_lamp_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NUM_DIGITS, 6, number of 7-segment digits, legal range 1..8.
  ACTIVE_LOW, 1, 1 = segment lit when its bit is 0.
  DIV_W, 24, width of the blink divider.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk, in, 1, single clock; every register is on its rising edge.
  reset, in, 1, synchronous, active-high.
  address, in, 4, Avalon-MM word address.
  write, in, 1, write strobe.
  writedata, in, 32, write data.
  read, in, 1, read strobe.
  readdata, out, 32, read data, fixed read latency of 1.
  lamps_export, out, 7*NUM_DIGITS, segment outputs; digit i occupies bits [7i+6:7i], bit order a..g = LSB..MSB.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.

Function
REQ-004 Register map by word address:
  0..NUM_DIGITS-1 is DIGIT[i]: [6:0] value, [7] enable.
  8 is CTRL: [0] decode_en, [1] blank_all.
  9 is BLINK_MASK: [NUM_DIGITS-1:0].
  10 is BLINK_DIV: [DIV_W-1:0].
  11 is STATUS, read-only: [0] blink_phase, [11:8] NUM_DIGITS.
REQ-005 A write SHALL update the addressed register at the clock edge where write=1; unused bits SHALL be ignored.
REQ-006 Writes to unmapped addresses, to DIGIT addresses >= NUM_DIGITS, and to STATUS SHALL have no effect.
REQ-007 readdata SHALL present the addressed register one cycle after read=1, with unused bits 0; unmapped addresses SHALL read 0; readdata SHALL be 0 in cycles without a preceding read.
REQ-008 If read and write are both asserted in the same cycle, the write SHALL take effect and readdata SHALL return the pre-write value.
REQ-009 Per-digit segment pattern, before polarity:
  decode_en=1: hex decode of value[3:0], covering 0-9 and A-F in the standard DE1-SoC glyph set.
  decode_en=0: value[6:0] used directly as the raw segment pattern.
REQ-010 A digit SHALL be blanked (all segments off) when any of these holds:
  its enable bit is 0;
  blank_all=1;
  its BLINK_MASK bit is 1 and blink_phase=1.
REQ-011 lamps_export SHALL be registered.
  Its latency from the write edge to the visible output change SHALL be exactly 1 cycle.
  When ACTIVE_LOW=1 the pattern SHALL be inverted, so that "off" means all ones.
REQ-012 Blink divider behaviour:
  A DIV_W-bit counter SHALL increment every cycle while BLINK_DIV != 0.
  On reaching BLINK_DIV-1 it SHALL wrap to 0 and toggle blink_phase in the same cycle.
  Each phase therefore lasts exactly BLINK_DIV cycles.
REQ-013 While BLINK_DIV=0, the counter and blink_phase SHALL be held at 0.
REQ-014 Any write to BLINK_DIV SHALL clear the counter and blink_phase on the same edge.
REQ-015 Changing BLINK_MASK SHALL NOT disturb the counter or blink_phase.

Reset
REQ-016 Reset SHALL clear all of the following:
  every DIGIT register, CTRL, BLINK_MASK and BLINK_DIV;
  the counter and blink_phase;
  readdata.
REQ-017 During reset and on the first cycle after it, lamps_export SHALL drive all segments off: all ones if ACTIVE_LOW=1, all zeros otherwise.
REQ-018 Reset asserted mid-blink SHALL override any concurrent write and return every state element to its reset value on the next edge.

Configuration
REQ-019 Macro LAMP_BLINK_EN:
  When defined, the divider, BLINK_MASK, BLINK_DIV and blink_phase SHALL be implemented exactly as described above.
  When undefined, none of them SHALL be implemented; addresses 9 and 10 SHALL behave as unmapped, and STATUS[0] SHALL read 0.

Verification
REQ-020 Reset: assert reset for 2 cycles -> lamps_export = 42'h3FFFFFFFFFF (NUM_DIGITS=6, ACTIVE_LOW=1); a read of address 0 returns 0.
REQ-021 Decode path: write CTRL=1, then DIGIT[0]=0x88 (enable, value 8) -> one cycle later lamps_export[6:0] = 7'b0000000, and bits [41:7] remain all ones.
REQ-022 Raw path: write CTRL=0, then DIGIT[5]=0x80|0x06 -> lamps_export[41:35] = 7'b1111001; a readback of address 5 returns 0x86.
REQ-023 Blink (LAMP_BLINK_EN defined): BLINK_DIV=4, BLINK_MASK=6'b000001, DIGIT[0] enabled -> digit 0 toggles lit/blank every 4 cycles, and STATUS[0] follows the phase.
REQ-024 Blink reset boundaries: write BLINK_DIV=0 mid-phase -> phase returns to 0 and digit 0 stays lit; assert reset during blink_phase=1 -> all digits are off next cycle and STATUS reads 0x600.
REQ-025 Address boundaries: write address 7 (>= NUM_DIGITS) and address 12 -> no output change and both read back as 0; simultaneous read and write of DIGIT[1] -> readdata returns the old value.

Source files
------------

// File: rtl/soc_lamp_ctrl.sv
// Avalon-MM 7-segment lamp controller: per-digit hex/raw patterns, blanking, optional blink.
// Blink divider, BLINK_MASK and BLINK_DIV exist only when LAMP_BLINK_EN is defined.
module soc_lamp_ctrl #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter int unsigned DIV_W      = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              address,
    input  logic                    write,
    input  logic [31:0]             writedata,
    input  logic                    read,
    output logic [31:0]             readdata,
    output logic [7*NUM_DIGITS-1:0] lamps_export
);

    localparam int unsigned LAMP_W = 7 * NUM_DIGITS;
    localparam logic [3:0] ADDR_CTRL   = 4'd8;
    localparam logic [3:0] ADDR_MASK   = 4'd9;
    localparam logic [3:0] ADDR_DIV    = 4'd10;
    localparam logic [3:0] ADDR_STATUS = 4'd11;
    localparam logic [LAMP_W-1:0] LAMPS_OFF = {LAMP_W{ACTIVE_LOW}};

    logic [7:0]            digit_q [NUM_DIGITS];
    logic [7:0]            digit_d [NUM_DIGITS];
    logic [1:0]            ctrl_q, ctrl_d;
    logic [31:0]           readdata_q, readdata_d;
    logic [LAMP_W-1:0]     lamps_q, lamps_d;
    logic [6:0]            seg;
    logic                  blink_phase;
    logic [NUM_DIGITS-1:0] blink_mask;
    logic                  unused_c;

    assign unused_c = ^writedata;

    // Standard DE1-SoC hex glyphs, segment a in bit 0, lit = 1.
    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_seg = 7'h3F;
            4'h1: hex_seg = 7'h06;
            4'h2: hex_seg = 7'h5B;
            4'h3: hex_seg = 7'h4F;
            4'h4: hex_seg = 7'h66;
            4'h5: hex_seg = 7'h6D;
            4'h6: hex_seg = 7'h7D;
            4'h7: hex_seg = 7'h07;
            4'h8: hex_seg = 7'h7F;
            4'h9: hex_seg = 7'h6F;
            4'hA: hex_seg = 7'h77;
            4'hB: hex_seg = 7'h7C;
            4'hC: hex_seg = 7'h39;
            4'hD: hex_seg = 7'h5E;
            4'hE: hex_seg = 7'h79;
            default: hex_seg = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
            ctrl_q     <= '0;
            readdata_q <= '0;
            lamps_q    <= LAMPS_OFF;
        end else begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) digit_q[i] <= digit_d[i];
            ctrl_q     <= ctrl_d;
            readdata_q <= readdata_d;
            lamps_q    <= lamps_d;
        end
    end

    always_comb begin
        ctrl_d = ctrl_q;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) digit_d[i] = digit_q[i];
        if (write) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (address == 4'(i)) digit_d[i] = writedata[7:0];
            end
            if (address == ADDR_CTRL) ctrl_d = writedata[1:0];
        end
    end

`ifdef LAMP_BLINK_EN
    logic [NUM_DIGITS-1:0] mask_q, mask_d;
    logic [DIV_W-1:0]      div_q, div_d, cnt_q, cnt_d;
    logic                  phase_q, phase_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q  <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            mask_q  <= mask_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    // A BLINK_DIV write restarts the phase; zero divider parks the counter.
    always_comb begin
        mask_d  = mask_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (write && address == ADDR_MASK) mask_d = writedata[NUM_DIGITS-1:0];
        if (write && address == ADDR_DIV) begin
            div_d   = writedata[DIV_W-1:0];
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (div_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == div_q - DIV_W'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    assign blink_phase = phase_q;
    assign blink_mask  = mask_q;
`else
    assign blink_phase = 1'b0;
    assign blink_mask  = '0;
`endif

    always_comb begin
        readdata_d = '0;
        if (read) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (address == 4'(i)) readdata_d = 32'(digit_q[i]);
            end
            case (address)
                ADDR_CTRL:   readdata_d = 32'(ctrl_q);
                ADDR_STATUS: readdata_d = {20'b0, 4'(NUM_DIGITS), 7'b0, blink_phase};
`ifdef LAMP_BLINK_EN
                ADDR_MASK:   readdata_d = 32'(mask_q);
                ADDR_DIV:    readdata_d = 32'(div_q);
`endif
                default:     ;
            endcase
        end
    end

    always_comb begin
        lamps_d = '0;
        seg     = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            seg = ctrl_q[0] ? hex_seg(digit_q[i][3:0]) : digit_q[i][6:0];
            if (!digit_q[i][7] || ctrl_q[1] || (blink_mask[i] && blink_phase)) seg = '0;
            lamps_d[7*i +: 7] = ACTIVE_LOW ? ~seg : seg;
        end
    end

    assign readdata     = readdata_q;
    assign lamps_export = lamps_q;

endmodule

// File: tb/tb_soc_lamp_ctrl.sv
// Directed bench for soc_lamp_ctrl (NUM_DIGITS=6, ACTIVE_LOW=1); blink steps follow LAMP_BLINK_EN.
module tb_soc_lamp_ctrl;

    localparam logic [41:0] ALL_OFF = 42'h3FF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic [41:0] lamps_export;

    int errors = 0;
    int checks = 0;
    logic [6:0]  exp_seg [6];
    logic [31:0] rdv;

    soc_lamp_ctrl #(.NUM_DIGITS(6), .ACTIVE_LOW(1'b1), .DIV_W(24)) dut (
        .clk(clk), .reset(reset), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(readdata),
        .lamps_export(lamps_export)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [41:0] pack();
        logic [41:0] r;
        for (int i = 0; i < 6; i++) r[7*i +: 7] = exp_seg[i];
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        @(posedge clk); #1;
        write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        @(posedge clk); #1;
        read = 1'b0;
        d = readdata;
    endtask

    initial begin
        reset = 1'b1; write = 1'b0; read = 1'b0; address = '0; writedata = '0;
        for (int i = 0; i < 6; i++) exp_seg[i] = 7'h7F;

        // Reset and first cycle after it
        tick(1);
        check("rst_lamps_c1", 64'(lamps_export), 64'(ALL_OFF));
        tick(1);
        check("rst_lamps_c2", 64'(lamps_export), 64'(ALL_OFF));
        check("rst_readdata", 64'(readdata), 64'h0);
        reset = 1'b0;
        tick(1);
        check("post_rst_lamps", 64'(lamps_export), 64'(ALL_OFF));
        rd(4'd0, rdv);
        check("rst_rd_digit0", 64'(rdv), 64'h0);

        // Decode path with exact 1-cycle latency
        wr(4'd8, 32'h1);
        wr(4'd0, 32'h88);
        check("latency_before", 64'(lamps_export), 64'(ALL_OFF));
        tick(1);
        exp_seg[0] = 7'b0000000;
        check("decode_8", 64'(lamps_export), 64'(pack()));

        // Raw path
        wr(4'd8, 32'h0);
        wr(4'd5, 32'h86);
        tick(1);
        exp_seg[0] = 7'b1110111;
        exp_seg[5] = 7'b1111001;
        check("raw_paths", 64'(lamps_export), 64'(pack()));
        rd(4'd5, rdv);
        check("rd_digit5", 64'(rdv), 64'h86);

        // Decode of several glyphs; unused write bits ignored
        wr(4'd8, 32'hFFFF_FFFD);
        wr(4'd1, 32'h8A);
        wr(4'd3, 32'hFFFF_FFFC);
        tick(1);
        exp_seg[0] = 7'b0000000;
        exp_seg[1] = 7'b0001000;
        exp_seg[3] = 7'b1000110;
        exp_seg[5] = 7'b0000010;
        check("decode_multi", 64'(lamps_export), 64'(pack()));
        rd(4'd8, rdv);
        check("rd_ctrl", 64'(rdv), 64'h1);
        rd(4'd3, rdv);
        check("rd_digit3", 64'(rdv), 64'hFC);

        // blank_all, then restore
        wr(4'd8, 32'h3);
        tick(1);
        check("blank_all", 64'(lamps_export), 64'(ALL_OFF));
        wr(4'd8, 32'h1);
        tick(1);
        check("unblank", 64'(lamps_export), 64'(pack()));

        // Disabled digit stays dark
        wr(4'd2, 32'h05);
        tick(1);
        check("digit_disabled", 64'(lamps_export), 64'(pack()));
        rd(4'd2, rdv);
        check("rd_digit2", 64'(rdv), 64'h05);

        // Address boundaries
        wr(4'd6, 32'h88);
        wr(4'd7, 32'h88);
        wr(4'd12, 32'hFF);
        wr(4'd11, 32'h0);
        tick(1);
        check("unmapped_wr", 64'(lamps_export), 64'(pack()));
        rd(4'd6, rdv);
        check("rd_addr6", 64'(rdv), 64'h0);
        rd(4'd7, rdv);
        check("rd_addr7", 64'(rdv), 64'h0);
        rd(4'd12, rdv);
        check("rd_addr12", 64'(rdv), 64'h0);
        rd(4'd11, rdv);
        check("rd_status", 64'(rdv), 64'h600);
        tick(1);
        check("readdata_idle", 64'(readdata), 64'h0);

        // Simultaneous read and write returns the old value
        address = 4'd1; writedata = 32'h83; write = 1'b1; read = 1'b1;
        @(posedge clk); #1;
        write = 1'b0; read = 1'b0;
        check("rw_old_value", 64'(readdata), 64'h8A);
        tick(1);
        exp_seg[1] = 7'b0110000;
        check("rw_new_lamps", 64'(lamps_export), 64'(pack()));
        rd(4'd1, rdv);
        check("rw_new_value", 64'(rdv), 64'h83);

`ifdef LAMP_BLINK_EN
        // Blink with BLINK_DIV=4 on digit 0; STATUS polled every cycle
        wr(4'd9, 32'hFFFF_FFC1);
        rd(4'd9, rdv);
        check("rd_mask", 64'(rdv), 64'h1);
        wr(4'd10, 32'h4);
        address = 4'd11; read = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            int ph;
            @(posedge clk); #1;
            ph = ((n - 1) / 4) % 2;
            exp_seg[0] = (ph != 0) ? 7'h7F : 7'h00;
            check($sformatf("blink_lamps_%0d", n), 64'(lamps_export), 64'(pack()));
            check($sformatf("blink_status_%0d", n), 64'(readdata), 64'(32'h600 | 32'(ph)));
        end
        read = 1'b0;

        // BLINK_DIV=0 mid-phase parks the phase at 0
        wr(4'd10, 32'h0);
        tick(1);
        exp_seg[0] = 7'h00;
        check("div0_lit", 64'(lamps_export), 64'(pack()));
        rd(4'd11, rdv);
        check("div0_status", 64'(rdv), 64'h600);
        tick(3);
        check("div0_still_lit", 64'(lamps_export), 64'(pack()));
        rd(4'd10, rdv);
        check("rd_div0", 64'(rdv), 64'h0);

        // Enter blink_phase=1 before the reset below
        wr(4'd10, 32'h2);
        tick(2);
        rd(4'd11, rdv);
        check("phase1_status", 64'(rdv), 64'h601);
`else
        wr(4'd9, 32'hFF);
        wr(4'd10, 32'h4);
        tick(1);
        check("noblink_lamps", 64'(lamps_export), 64'(pack()));
        rd(4'd9, rdv);
        check("noblink_rd9", 64'(rdv), 64'h0);
        rd(4'd10, rdv);
        check("noblink_rd10", 64'(rdv), 64'h0);
`endif

        // Reset overrides a concurrent write
        reset = 1'b1; address = 4'd0; writedata = 32'h88; write = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; write = 1'b0;
        for (int i = 0; i < 6; i++) exp_seg[i] = 7'h7F;
        check("midrst_lamps", 64'(lamps_export), 64'(ALL_OFF));
        check("midrst_readdata", 64'(readdata), 64'h0);
        tick(1);
        check("midrst_lamps_after", 64'(lamps_export), 64'(ALL_OFF));
        rd(4'd11, rdv);
        check("midrst_status", 64'(rdv), 64'h600);
        rd(4'd0, rdv);
        check("midrst_digit0", 64'(rdv), 64'h0);
        rd(4'd8, rdv);
        check("midrst_ctrl", 64'(rdv), 64'h0);
`ifdef LAMP_BLINK_EN
        rd(4'd10, rdv);
        check("midrst_div", 64'(rdv), 64'h0);
        rd(4'd9, rdv);
        check("midrst_mask", 64'(rdv), 64'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
